// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: sequencer for a left shift register.
// Loads a word, then streams it MSB-first under ser_ready.
module shiftreg_ctrl #(
  parameter int WIDTH = 6,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_count,
  output logic             sr_rst,
  output logic             sr_en,
  output logic [WIDTH-1:0] sr_load,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] MAXC = CW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [CW-1:0]    cnt_clamp;

  logic st_idle, st_load, st_shift, st_done;

  assign st_idle  = (state_q == IDLE);
  assign st_load  = (state_q == LOAD);
  assign st_shift = (state_q == SHIFT);
  assign st_done  = (state_q == DONE);

  assign cnt_clamp = (in_count > MAXC) ? MAXC : in_count;

  // Next-state and word/count capture.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (1'b1)
      st_idle: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = cnt_clamp;
          state_d = LOAD;
        end
      end
      st_load: begin
        state_d = (rem_q != '0) ? SHIFT : DONE;
      end
      st_shift: begin
        if (ser_ready) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1))
            state_d = DONE;
        end
      end
      st_done: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // While in reset the datapath is cleared through its load port.
  assign in_ready  = rst_n & st_idle;
  assign sr_rst    = ~rst_n | st_load;
  assign sr_load   = st_load ? data_q : '0;
  assign ser_valid = rst_n & st_shift;
  assign sr_en     = ser_valid & ser_ready;
  assign ser_out   = ser_valid & sr_q[WIDTH-1];
  assign busy      = rst_n & ~st_idle;
  assign done      = rst_n & st_done;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb_shiftreg_ctrl: directed bench for shiftreg_ctrl.
// Includes a behavioural model of the attached shift register.
module tb_shiftreg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [2:0] in_count;
  logic       sr_rst;
  logic       sr_en;
  logic [5:0] sr_load;
  logic [5:0] sr_q;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       busy;
  logic       done;

  int ncmp = 0;
  int nerr = 0;

  shiftreg_ctrl #(.WIDTH(6), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .sr_rst    (sr_rst),
    .sr_en     (sr_en),
    .sr_load   (sr_load),
    .sr_q      (sr_q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register datapath model.
  always @(posedge clk) begin
    if (sr_rst)
      sr_q <= sr_load;
    else if (sr_en)
      sr_q <= {sr_q[4:0], 1'b0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [5:0] data,
                      input logic [2:0] cnt, input int exp_n,
                      input logic [5:0] exp_bits, input bit bp,
                      input int exp_k, input bit nxt,
                      input logic [5:0] nxt_data,
                      input logic [2:0] nxt_cnt);
    int k;
    int nb;
    int nval;
    bit seen;
    bit prev_stall;
    logic prev_out;
    logic [5:0] bits;
    logic [5:0] fin;
    in_valid = 1'b1;
    in_data  = data;
    in_count = cnt;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (in_ready) seen = 1'b1;
      else step();
    end
    chk({tag, " accept"}, 8'(seen), 8'd1);
    step();
    if (nxt) begin
      in_data  = nxt_data;
      in_count = nxt_cnt;
    end else begin
      in_valid = 1'b0;
    end
    chk({tag, " load sr_rst"}, 8'(sr_rst), 8'd1);
    chk({tag, " load sr_load"}, 8'(sr_load), 8'(data));
    chk({tag, " load busy"}, 8'(busy), 8'd1);
    chk({tag, " load ser_valid"}, 8'(ser_valid), 8'd0);
    k = 0;
    nb = 0;
    nval = 0;
    bits = '0;
    seen = 1'b0;
    prev_stall = 1'b0;
    prev_out = 1'b0;
    while (!seen && k < 60) begin
      step();
      k++;
      ser_ready = bp ? (((k - 1) % 3) == 0) : 1'b1;
      #1;
      chk({tag, " in_ready busy"}, 8'(in_ready), 8'd0);
      if (ser_valid) begin
        nval++;
        chk({tag, " sr_en"}, 8'(sr_en), 8'(ser_ready));
        if (prev_stall)
          chk({tag, " stall stable"}, 8'(ser_out), 8'(prev_out));
        if (ser_ready) begin
          bits = {bits[4:0], ser_out};
          nb++;
        end
        prev_stall = !ser_ready;
        prev_out = ser_out;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, " done cycle"}, 8'(k), 8'(exp_k));
      end
    end
    chk({tag, " done seen"}, 8'(seen), 8'd1);
    chk({tag, " nbits"}, 8'(nb), 8'(exp_n));
    chk({tag, " bits"}, 8'(bits), 8'(exp_bits));
    chk({tag, " no valid"}, 8'(nval == 0), 8'(exp_n == 0));
    step();
    fin = data << exp_n;
    chk({tag, " done once"}, 8'(done), 8'd0);
    chk({tag, " idle ready"}, 8'(in_ready), 8'd1);
    chk({tag, " idle busy"}, 8'(busy), 8'd0);
    chk({tag, " residual"}, 8'(sr_q), 8'(fin));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 6'h3F;
    in_count = 3'd6;
    ser_ready = 1'b0;
    #1;
    chk("rst in_ready", 8'(in_ready), 8'd0);
    chk("rst sr_rst", 8'(sr_rst), 8'd1);
    chk("rst sr_load", 8'(sr_load), 8'd0);
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst done", 8'(done), 8'd0);
    chk("rst ser_valid", 8'(ser_valid), 8'd0);
    chk("rst sr_en", 8'(sr_en), 8'd0);
    step();
    chk("rst sr_q", 8'(sr_q), 8'd0);
    step();
    step();
    chk("rst hold busy", 8'(busy), 8'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel in_ready", 8'(in_ready), 8'd1);
    chk("rel sr_rst", 8'(sr_rst), 8'd0);

    xfer("full", 6'b000111, 3'd6, 6, 6'b000111, 1'b0, 7,
         1'b0, 6'd0, 3'd0);
    xfer("part", 6'b101100, 3'd3, 3, 6'b000101, 1'b0, 4,
         1'b0, 6'd0, 3'd0);
    xfer("clamp", 6'b101100, 3'd7, 6, 6'b101100, 1'b0, 7,
         1'b0, 6'd0, 3'd0);
    xfer("bp", 6'b110010, 3'd6, 6, 6'b110010, 1'b1, 17,
         1'b0, 6'd0, 3'd0);
    xfer("zero", 6'b111111, 3'd0, 0, 6'b000000, 1'b0, 1,
         1'b1, 6'b100110, 3'd5);
    xfer("b2b", 6'b100110, 3'd5, 5, 6'b010011, 1'b0, 6,
         1'b0, 6'd0, 3'd0);

    in_valid = 1'b1;
    in_data = 6'b101010;
    in_count = 3'd6;
    ser_ready = 1'b1;
    chk("abort accept", 8'(in_ready), 8'd1);
    step();
    in_valid = 1'b0;
    step();
    chk("abort bit1", 8'(ser_out), 8'd1);
    step();
    chk("abort bit2", 8'(ser_out), 8'd0);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort busy", 8'(busy), 8'd0);
    chk("abort ser_valid", 8'(ser_valid), 8'd0);
    chk("abort done", 8'(done), 8'd0);
    chk("abort in_ready", 8'(in_ready), 8'd0);
    chk("abort sr_rst", 8'(sr_rst), 8'd1);
    step();
    chk("abort sr_q", 8'(sr_q), 8'd0);
    chk("abort done2", 8'(done), 8'd0);
    rst_n = 1'b1;
    step();
    chk("abort done3", 8'(done), 8'd0);
    chk("abort ready", 8'(in_ready), 8'd1);
    xfer("after", 6'b011111, 3'd6, 6, 6'b011111, 1'b0, 7,
         1'b0, 6'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
